uart_tx_cfg: RTL

Parametrised, runtime-configurable UART transmitter; next generation of the single-byte serialiser. Adds a TX FIFO, configurable data width, parity, one or two stop bits, and a runtime baud divisor. Sits between the AHB-lite UART register slave (FIFO write side) and the pad (serial_out).

---
 rtl/uart_tx_cfg_if.sv | 24 ++
 rtl/uart_tx_cfg.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg_if.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg_if
//   Write-side handshake into the uart_tx_cfg TX FIFO.
//
//   Signals:
//     in_data   word to transmit, sent LSB first
//     in_valid  write request from the register slave
//     in_ready  FIFO not full; a word is taken on an edge where
//               in_valid && in_ready
//
//   Modports:
//     master  register-slave side (drives data/valid)
//     slave   transmitter side (drives ready)
// ---------------------------------------------------------------------------
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//   Runtime-configurable UART transmitter with a TX FIFO. Words arrive
//   through the uart_tx_cfg_if slave modport, are queued, and are serialised
//   as: start bit, DATA_WIDTH data bits (LSB first), optional parity bit,
//   one or two stop bits. Back-to-back frames are sent with no idle gap.
//
//   Ports:
//     clk          system clock, all logic on posedge
//     n_rst        asynchronous active-low reset
//     bus          uart_tx_cfg_if.slave (in_data / in_valid / in_ready)
//     baud_div     clocks per bit; values below 2 select DEF_DIV
//     parity_mode  00 none, 01 even, 10 odd, 11 none
//     stop2        1 = two stop bits, 0 = one
//     break_req    (only with UART_TX_BREAK_EN) hold the line low when idle
//     serial_out   registered line output, idle high
//     tx_busy      high while a frame (or a line break) is in progress
//     fifo_count   number of words queued
//     tx_done      one-cycle pulse on the last clock of the final stop bit
//
//   Optional feature macro: UART_TX_BREAK_EN
//     When defined, adds break_req. A break only starts between frames, and
//     after it is released the line stays high for one full bit time before
//     the next start bit. When undefined the port and logic are absent.
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          n_rst,
  uart_tx_cfg_if.slave                  bus,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_req,
`endif
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(CLK_FREQ / BAUD_RATE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wrPtr;
  logic [AW-1:0]         r_rdPtr;
  logic [AW:0]           r_count;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  r_bitCnt;
  logic [IW-1:0]         r_bitIdx;
  logic                  r_stopIdx;
  logic                  r_stop2;
  logic                  r_parEn;
  logic                  r_parity;
  logic                  r_serial;
  logic                  r_busy;
  logic                  r_txDone;

  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_lastTick;
  logic                  w_frameEnd;
  logic                  w_doneNext;
  logic                  w_hold;
  logic [DIV_WIDTH-1:0]  w_effDiv;
  logic [DATA_WIDTH-1:0] w_head;

`ifdef UART_TX_BREAK_EN
  logic                  r_breakActive;
  logic                  r_guardActive;
`endif

  assign w_ready      = (r_count != (AW+1)'(FIFO_DEPTH));
  assign bus.in_ready = w_ready;
  assign w_push       = bus.in_valid && w_ready;
  assign w_empty      = (r_count == '0);
  assign w_head       = r_mem[r_rdPtr];
  assign w_effDiv     = (baud_div < DIV_WIDTH'(2)) ? DEF_DIV : baud_div;

  // The bit timer runs 0..r_div-1; r_bitCnt is reused as the post-break
  // guard timer while idle.
  assign w_lastTick = (r_bitCnt == r_div - DIV_WIDTH'(1));
  assign w_frameEnd = (r_state == ST_STOP) && w_lastTick && (r_stopIdx == r_stop2);

  // tx_done is registered, so it is raised one clock early to land on the
  // final clock of the last stop bit.
  assign w_doneNext = (r_state == ST_STOP) && (r_stopIdx == r_stop2) &&
                      (r_bitCnt == r_div - DIV_WIDTH'(2));

`ifdef UART_TX_BREAK_EN
  // A pending or active break, or an unfinished guard bit, holds off the
  // next frame; the guard's final clock lets a start bit follow directly.
  assign w_hold = break_req || r_breakActive || (r_guardActive && !w_lastTick);
`else
  assign w_hold = 1'b0;
`endif

  // A frame starts from IDLE, or chains straight out of the last stop clock.
  assign w_pop = !w_empty && !w_hold && ((r_state == ST_IDLE) || w_frameEnd);

  // FIFO storage has no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= bus.in_data;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at FIFO_DEPTH;
  // a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  // Frame FSM. Frame configuration is captured when the word is popped and
  // held for the whole frame, so input changes only affect the next frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_div     <= '0;
      r_bitCnt  <= '0;
      r_bitIdx  <= '0;
      r_stopIdx <= 1'b0;
      r_stop2   <= 1'b0;
      r_parEn   <= 1'b0;
      r_parity  <= 1'b0;
      r_serial  <= 1'b1;
      r_busy    <= 1'b0;
      r_txDone  <= 1'b0;
`ifdef UART_TX_BREAK_EN
      r_breakActive <= 1'b0;
      r_guardActive <= 1'b0;
`endif
    end else begin
      r_txDone <= w_doneNext;
      if (w_pop) begin
        r_state   <= ST_START;
        r_shift   <= w_head;
        r_div     <= w_effDiv;
        r_parEn   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        r_parity  <= (^w_head) ^ (parity_mode == 2'b10);
        r_stop2   <= stop2;
        r_bitCnt  <= '0;
        r_bitIdx  <= '0;
        r_stopIdx <= 1'b0;
        r_serial  <= 1'b0;
        r_busy    <= 1'b1;
`ifdef UART_TX_BREAK_EN
        r_breakActive <= 1'b0;
        r_guardActive <= 1'b0;
`endif
      end else begin
        unique case (r_state)
          ST_START: begin
            if (w_lastTick) begin
              r_bitCnt <= '0;
              r_state  <= ST_DATA;
              r_serial <= r_shift[0];
            end else begin
              r_bitCnt <= r_bitCnt + DIV_WIDTH'(1);
            end
          end
          ST_DATA: begin
            if (w_lastTick) begin
              r_bitCnt <= '0;
              if (r_bitIdx == IW'(DATA_WIDTH - 1)) begin
                if (r_parEn) begin
                  r_state  <= ST_PARITY;
                  r_serial <= r_parity;
                end else begin
                  r_state   <= ST_STOP;
                  r_serial  <= 1'b1;
                  r_stopIdx <= 1'b0;
                end
              end else begin
                r_bitIdx <= r_bitIdx + IW'(1);
                r_serial <= r_shift[1];
                r_shift  <= r_shift >> 1;
              end
            end else begin
              r_bitCnt <= r_bitCnt + DIV_WIDTH'(1);
            end
          end
          ST_PARITY: begin
            if (w_lastTick) begin
              r_bitCnt  <= '0;
              r_state   <= ST_STOP;
              r_serial  <= 1'b1;
              r_stopIdx <= 1'b0;
            end else begin
              r_bitCnt <= r_bitCnt + DIV_WIDTH'(1);
            end
          end
          ST_STOP: begin
            if (w_lastTick) begin
              r_bitCnt <= '0;
              if (r_stopIdx != r_stop2) begin
                r_stopIdx <= 1'b1;
              end else begin
                r_state  <= ST_IDLE;
                r_serial <= 1'b1;
                r_busy   <= 1'b0;
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                  r_breakActive <= 1'b1;
                  r_div         <= w_effDiv;
                  r_serial      <= 1'b0;
                  r_busy        <= 1'b1;
                end
`endif
              end
            end else begin
              r_bitCnt <= r_bitCnt + DIV_WIDTH'(1);
            end
          end
          default: begin
`ifdef UART_TX_BREAK_EN
            // Idle break handling: drive low while requested, then one
            // guard bit of high line timed with the divisor latched at
            // break entry.
            if (break_req) begin
              if (!r_breakActive) begin
                r_div <= w_effDiv;
              end
              r_breakActive <= 1'b1;
              r_guardActive <= 1'b0;
              r_serial      <= 1'b0;
              r_busy        <= 1'b1;
            end else if (r_breakActive) begin
              r_breakActive <= 1'b0;
              r_guardActive <= 1'b1;
              r_bitCnt      <= '0;
              r_serial      <= 1'b1;
              r_busy        <= 1'b0;
            end else if (r_guardActive) begin
              if (w_lastTick) begin
                r_guardActive <= 1'b0;
              end else begin
                r_bitCnt <= r_bitCnt + DIV_WIDTH'(1);
              end
            end
`endif
          end
        endcase
      end
    end
  end

  assign serial_out = r_serial;
  assign tx_busy    = r_busy;
  assign fifo_count = r_count;
  assign tx_done    = r_txDone;

endmodule
